ncc_peak_finder: RTL

//  Downstream of ncc: consumes per-position correlation scores (accOut lanes) for one

---
 rtl/ncc_peak_finder.sv | 95 +++++++++
 1 files changed

// File: rtl/ncc_peak_finder.sv
// ncc_peak_finder: scans one frame of NCC score beats in raster order and reports the
// first position holding the maximum score, with a threshold match flag, via valid/ready.
module ncc_peak_finder #(
    parameter int LANES = 8,
    parameter int SCORE_W = 16,
    parameter int COL_BEATS = 4,
    parameter int ROWS = 32,
    localparam int X_W = $clog2(LANES * COL_BEATS),
    localparam int Y_W = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SCORE_W-1:0]       thresh,
    input  logic                     score_valid,
    output logic                     score_ready,
    input  logic [LANES*SCORE_W-1:0] score,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [X_W-1:0]           best_x,
    output logic [Y_W-1:0]           best_y,
    output logic [SCORE_W-1:0]       best_score,
    output logic                     match
);
    localparam int C_W = COL_BEATS > 1 ? $clog2(COL_BEATS) : 1;
    localparam int L_W = LANES > 1 ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t state, state_next;
    logic [C_W-1:0] col;
    logic [Y_W-1:0] row;
    logic first;
    logic [SCORE_W-1:0] lane_max, best_score_next;
    logic [L_W-1:0] lane_idx;
    logic accept, col_last, last, upd;

    assign score_ready = state == SCAN;
    assign result_valid = state == HOLD;
    assign accept = score_valid && score_ready;
    assign col_last = col == C_W'(COL_BEATS - 1);
    assign last = col_last && row == Y_W'(ROWS - 1);
    // strict compare against the running best keeps the raster-order first occurrence
    assign upd = accept && (first || lane_max > best_score);
    assign best_score_next = upd ? lane_max : best_score;

    always_comb begin
        lane_max = score[SCORE_W-1:0];
        lane_idx = '0;
        for (int i = 1; i < LANES; i++)
            if (score[i*SCORE_W +: SCORE_W] > lane_max) begin
                lane_max = score[i*SCORE_W +: SCORE_W];
                lane_idx = L_W'(i);
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = start ? SCAN : IDLE;
            SCAN:    state_next = accept && last ? HOLD : SCAN;
            HOLD:    state_next = result_ready ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            col <= '0;
            row <= '0;
            first <= 1'b0;
            best_x <= '0;
            best_y <= '0;
            best_score <= '0;
            match <= 1'b0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
            first <= 1'b1;
        end else if (accept) begin
            first <= 1'b0;
            col <= col_last ? '0 : col + 1'b1;
            row <= last ? '0 : col_last ? row + 1'b1 : row;
            if (upd) begin
                best_x <= X_W'(col) * X_W'(LANES) + X_W'(lane_idx);
                best_y <= row;
                best_score <= lane_max;
            end
            if (last) match <= best_score_next >= thresh;
        end
endmodule
